// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// The master side is the controller. It receives the instruction fields and
// the condition and memory status, and it drives the datapath mux selects
// and write enables. The slave side is the datapath and instruction register.
interface multicycle_ctrl_if;
    // Instruction fields and status, driven by the datapath
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       cond_ex;
    logic       mem_ready;

    // Enables and selects, driven by the controller
    logic       ir_write;
    logic       pc_write;
    logic       adr_src;
    logic       mem_w;
    logic       reg_w;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [2:0] alu_control;
    logic [1:0] flag_w;
    logic       shift_flag;
    logic       instr_done;
    logic       undef;

    modport master (
        input  op, funct, rd, cond_ex, mem_ready,
        output ir_write, pc_write, adr_src, mem_w, reg_w, alu_src_a,
               alu_src_b, result_src, imm_src, reg_src, alu_control,
               flag_w, shift_flag, instr_done, undef
    );

    modport slave (
        output op, funct, rd, cond_ex, mem_ready,
        input  ir_write, pc_write, adr_src, mem_w, reg_w, alu_src_a,
               alu_src_b, result_src, imm_src, reg_src, alu_control,
               flag_w, shift_flag, instr_done, undef
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle CPU build.
// The FSM steps a shared datapath (one memory port, one ALU) through the
// fetch, decode, execute, memory and writeback steps.
// Configuration macro MCCTRL_STALL_EN:
//   defined   - FETCH, MEMRD and MEMWR wait for mem_ready.
//   undefined - mem_ready is ignored, and each of those states lasts one cycle.
module multicycle_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    // Instruction class (op field)
    localparam logic [1:0] OP_DP  = 2'd0;
    localparam logic [1:0] OP_MEM = 2'd1;
    localparam logic [1:0] OP_BR  = 2'd2;

    // Data-processing command codes (funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ADC = 4'b0101;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_LSL = 4'b1101;

    // ALU command codes shared with the single-cycle decoder
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_ADC = 3'b100;

    // Mux select encodings
    localparam logic [1:0] SRCB_RM    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] IMM_DP     = 2'b00;
    localparam logic [1:0] IMM_MEM    = 2'b01;
    localparam logic [1:0] IMM_BR     = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       adr_src;
        logic       mem_w;
        logic       reg_w;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic [2:0] alu_control;
        logic [1:0] flag_w;
        logic       shift_flag;
        logic       instr_done;
        logic       undef;
    } ctl_t;

    state_t     state;
    ctl_t       ctl;
    logic       ready;
    logic [3:0] cmd;
    logic       s_bit;
    logic [2:0] alu_cmd;
    logic       no_wb;
    logic       dst_pc;

    // Map a data-processing command to an ALU operation.
    function automatic logic [2:0] alu_decode(input logic [3:0] c);
        case (c)
            CMD_ADD: alu_decode = ALU_ADD;
            CMD_SUB: alu_decode = ALU_SUB;
            CMD_AND: alu_decode = ALU_AND;
            CMD_ORR: alu_decode = ALU_ORR;
            CMD_CMP: alu_decode = ALU_SUB;
            CMD_TST: alu_decode = ALU_AND;
            CMD_CMN: alu_decode = ALU_ADD;
            CMD_ADC: alu_decode = ALU_ADC;
            default: alu_decode = ALU_ADD;  // lsl and unlisted commands
        endcase
    endfunction

`ifdef MCCTRL_STALL_EN
    assign ready = bus.mem_ready;
`else
    // Memory is always treated as ready. Keep the port tied off so that it
    // is visibly unused.
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign ready            = 1'b1;
`endif

    assign cmd     = bus.funct[4:1];
    assign s_bit   = bus.funct[0];
    assign alu_cmd = alu_decode(cmd);
    // Compare-type commands only update flags and skip the writeback step.
    assign no_wb   = (cmd == CMD_CMP) || (cmd == CMD_TST) || (cmd == CMD_CMN);
    assign dst_pc  = (bus.rd == 4'd15);

    // State register: move to the next step of the instruction.
    // NOTE: sequential state uses non-blocking (<=) assignments, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  if (ready) state <= S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        OP_DP:   state <= bus.funct[5] ? S_EXECI : S_EXECR;
                        OP_MEM:  state <= S_MEMADR;
                        OP_BR:   state <= S_BRANCH;
                        default: state <= S_FETCH;   // undefined op
                    endcase
                end
                S_EXECR,
                S_EXECI:  state <= no_wb ? S_FETCH : S_ALUWB;
                S_ALUWB:  state <= S_FETCH;
                S_MEMADR: state <= bus.funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (ready) state <= S_MEMWB;
                S_MEMWB:  state <= S_FETCH;
                S_MEMWR:  if (ready) state <= S_FETCH;
                S_BRANCH: state <= S_FETCH;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Output decode. The outputs come from the state, but the gated enables
    // also follow cond_ex and mem_ready in the same cycle, and reset forces
    // every output to zero immediately.
    // NOTE: every field gets a default before the case statement, so no path
    // leaves an output unassigned and no latch is inferred.
    always_comb begin
        ctl = '0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    ctl.adr_src     = 1'b0;
                    ctl.alu_src_a   = 1'b1;
                    ctl.alu_src_b   = SRCB_FOUR;
                    ctl.result_src  = RES_ALU;
                    ctl.alu_control = ALU_ADD;
                    ctl.ir_write    = ready;
                    ctl.pc_write    = ready;
                end
                S_DECODE: begin
                    // Forms PC+8 while the register file reads the operands.
                    ctl.alu_src_a   = 1'b1;
                    ctl.alu_src_b   = SRCB_FOUR;
                    ctl.result_src  = RES_ALU;
                    ctl.alu_control = ALU_ADD;
                    case (bus.op)
                        OP_DP:  ctl.imm_src = IMM_DP;
                        OP_MEM: begin
                            ctl.imm_src = IMM_MEM;
                            ctl.reg_src = 2'b10;   // read Rd as store data
                        end
                        OP_BR: begin
                            ctl.imm_src = IMM_BR;
                            ctl.reg_src = 2'b01;   // read PC as base
                        end
                        default: begin
                            ctl.undef      = 1'b1;
                            ctl.instr_done = 1'b1;
                        end
                    endcase
                end
                S_EXECR,
                S_EXECI: begin
                    ctl.alu_src_a   = 1'b0;
                    ctl.alu_src_b   = (state == S_EXECI) ? SRCB_IMM : SRCB_RM;
                    ctl.alu_control = alu_cmd;
                    ctl.shift_flag  = (cmd == CMD_LSL);
                    ctl.flag_w[1]   = s_bit & bus.cond_ex;
                    ctl.flag_w[0]   = s_bit & bus.cond_ex &
                                      ((alu_cmd == ALU_ADD) ||
                                       (alu_cmd == ALU_SUB) ||
                                       (alu_cmd == ALU_ADC));
                    ctl.instr_done  = no_wb;
                end
                S_ALUWB: begin
                    ctl.result_src = RES_ALUOUT;
                    ctl.reg_w      = bus.cond_ex;
                    ctl.pc_write   = bus.cond_ex & dst_pc;
                    ctl.instr_done = 1'b1;
                end
                S_MEMADR: begin
                    ctl.alu_src_a   = 1'b0;
                    ctl.alu_src_b   = SRCB_IMM;
                    ctl.imm_src     = IMM_MEM;
                    ctl.alu_control = ALU_ADD;
                end
                S_MEMRD: begin
                    ctl.adr_src = 1'b1;
                end
                S_MEMWB: begin
                    ctl.result_src = RES_DATA;
                    ctl.reg_w      = bus.cond_ex;
                    ctl.pc_write   = bus.cond_ex & dst_pc;
                    ctl.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    // The write stays up for the whole access. A failed
                    // condition still waits for the memory, with mem_w low.
                    ctl.adr_src    = 1'b1;
                    ctl.mem_w      = bus.cond_ex;
                    ctl.instr_done = ready;
                end
                S_BRANCH: begin
                    ctl.alu_src_a   = 1'b0;
                    ctl.alu_src_b   = SRCB_IMM;
                    ctl.imm_src     = IMM_BR;
                    ctl.result_src  = RES_ALU;
                    ctl.alu_control = ALU_ADD;
                    ctl.pc_write    = bus.cond_ex;
                    ctl.instr_done  = 1'b1;
                end
                default: ctl = '0;
            endcase
        end
    end

    assign bus.ir_write    = ctl.ir_write;
    assign bus.pc_write    = ctl.pc_write;
    assign bus.adr_src     = ctl.adr_src;
    assign bus.mem_w       = ctl.mem_w;
    assign bus.reg_w       = ctl.reg_w;
    assign bus.alu_src_a   = ctl.alu_src_a;
    assign bus.alu_src_b   = ctl.alu_src_b;
    assign bus.result_src  = ctl.result_src;
    assign bus.imm_src     = ctl.imm_src;
    assign bus.reg_src     = ctl.reg_src;
    assign bus.alu_control = ctl.alu_control;
    assign bus.flag_w      = ctl.flag_w;
    assign bus.shift_flag  = ctl.shift_flag;
    assign bus.instr_done  = ctl.instr_done;
    assign bus.undef       = ctl.undef;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. For each instruction, a reference model
// builds the expected per-cycle control vector from the instruction class,
// the condition result and the requested memory stalls. The bench then
// compares the DUT against that vector one cycle at a time.
module tb_multicycle_ctrl;
`ifdef MCCTRL_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    multicycle_ctrl_if bus_if();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       adr_src;
        logic       mem_w;
        logic       reg_w;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic [2:0] alu_control;
        logic [1:0] flag_w;
        logic       shift_flag;
        logic       instr_done;
        logic       undef;
    } ctl_t;

    ctl_t exp_q[$];
    logic rdy_q[$];
    logic [2:0] alu_tab [16];
    int checks   = 0;
    int failures = 0;

    function automatic ctl_t observe();
        ctl_t o;
        o.ir_write    = bus_if.ir_write;
        o.pc_write    = bus_if.pc_write;
        o.adr_src     = bus_if.adr_src;
        o.mem_w       = bus_if.mem_w;
        o.reg_w       = bus_if.reg_w;
        o.alu_src_a   = bus_if.alu_src_a;
        o.alu_src_b   = bus_if.alu_src_b;
        o.result_src  = bus_if.result_src;
        o.imm_src     = bus_if.imm_src;
        o.reg_src     = bus_if.reg_src;
        o.alu_control = bus_if.alu_control;
        o.flag_w      = bus_if.flag_w;
        o.shift_flag  = bus_if.shift_flag;
        o.instr_done  = bus_if.instr_done;
        o.undef       = bus_if.undef;
        return o;
    endfunction

    function automatic logic rnd_bit();
        return ($urandom_range(1) != 0);
    endfunction

    task automatic push(input ctl_t v, input logic r);
        exp_q.push_back(v);
        rdy_q.push_back(r);
    endtask

    // Reference model. It expands one instruction into its expected cycles.
    // fs and ms are the requested wait cycles in fetch and in the memory
    // access. These cycles exist only when the stall handshake is built in.
    task automatic build(input logic [1:0] op, input logic [5:0] funct,
                         input logic [3:0] rd, input logic cond,
                         input int fs, input int ms);
        ctl_t       v;
        logic [3:0] cmd;
        logic [2:0] alu;
        logic       no_wb;
        cmd = funct[4:1];
        exp_q.delete();
        rdy_q.delete();
        bus_if.op      = op;
        bus_if.funct   = funct;
        bus_if.rd      = rd;
        bus_if.cond_ex = cond;

        // Fetch: PC+4 through the ALU, with the IR/PC load gated by memory
        v = '0;
        v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.result_src = 2'b10;
        if (STALL) for (int i = 0; i < fs; i++) push(v, 1'b0);
        v.ir_write = 1'b1; v.pc_write = 1'b1;
        push(v, STALL ? 1'b1 : (fs == 0));

        // Decode: PC+8, with the extender and register source set by op
        v = '0;
        v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.result_src = 2'b10;
        if (op == 2'd3) begin
            v.undef = 1'b1; v.instr_done = 1'b1;
            push(v, rnd_bit());
            return;
        end
        v.imm_src = op;
        v.reg_src = {op == 2'd1, op == 2'd2};
        push(v, rnd_bit());

        if (op == 2'd0) begin
            alu   = alu_tab[cmd];
            no_wb = cmd inside {4'b1010, 4'b1000, 4'b1011};
            v = '0;
            v.alu_src_b   = funct[5] ? 2'b01 : 2'b00;
            v.alu_control = alu;
            v.shift_flag  = (cmd == 4'b1101);
            v.flag_w[1]   = funct[0] & cond;
            v.flag_w[0]   = funct[0] & cond & (alu inside {3'b000, 3'b001, 3'b100});
            v.instr_done  = no_wb;
            push(v, rnd_bit());
            if (!no_wb) begin
                v = '0;
                v.reg_w = cond; v.pc_write = cond && (rd == 4'd15);
                v.instr_done = 1'b1;
                push(v, rnd_bit());
            end
        end else if (op == 2'd1) begin
            v = '0;
            v.alu_src_b = 2'b01; v.imm_src = 2'b01;
            push(v, rnd_bit());
            if (funct[0]) begin
                v = '0; v.adr_src = 1'b1;
                if (STALL) for (int i = 0; i < ms; i++) push(v, 1'b0);
                push(v, STALL ? 1'b1 : (ms == 0));
                v = '0;
                v.result_src = 2'b01; v.reg_w = cond;
                v.pc_write = cond && (rd == 4'd15); v.instr_done = 1'b1;
                push(v, rnd_bit());
            end else begin
                v = '0; v.adr_src = 1'b1; v.mem_w = cond;
                if (STALL) for (int i = 0; i < ms; i++) push(v, 1'b0);
                v.instr_done = 1'b1;
                push(v, STALL ? 1'b1 : (ms == 0));
            end
        end else begin
            v = '0;
            v.alu_src_b = 2'b01; v.imm_src = 2'b10; v.result_src = 2'b10;
            v.pc_write = cond; v.instr_done = 1'b1;
            push(v, rnd_bit());
        end
    endtask

    // Apply the first n model cycles. Entry and exit are at posedge+1.
    task automatic play(input int n, input string name, output int dones);
        ctl_t got;
        dones = 0;
        for (int i = 0; i < n; i++) begin
            bus_if.mem_ready = rdy_q[i];
            @(negedge clk);
            got = observe();
            checks++;
            if (got !== exp_q[i]) begin
                failures++;
                $display("FAIL %s cycle %0d: got=%h expected=%h", name, i, got, exp_q[i]);
            end
            dones += int'(got.instr_done);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input string name, input logic [1:0] op,
                             input logic [5:0] funct, input logic [3:0] rd,
                             input logic cond, input int fs, input int ms);
        int dones;
        build(op, funct, rd, cond, fs, ms);
        play(exp_q.size(), name, dones);
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL %s instr_done_count: got=%0d expected=1", name, dones);
        end
    endtask

    task automatic test_reset();
        ctl_t got;
        rst_n = 1'b0;
        bus_if.op = 2'd2; bus_if.funct = 6'($urandom); bus_if.rd = 4'd15;
        bus_if.cond_ex = 1'b1; bus_if.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = observe();
            checks++;
            if (got !== '0) begin
                failures++;
                $display("FAIL reset_outputs_zero: got=%h expected=0", got);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_branch();
        run_instr("branch", 2'd2, 6'($urandom), 4'($urandom), 1'b1, 0, 0);
        run_instr("branch_nocond", 2'd2, 6'($urandom), 4'($urandom), 1'b0, 0, 0);
    endtask

    task automatic test_dp();
        run_instr("add_imm_s", 2'd0, 6'b101001, 4'd3, 1'b1, 0, 0);
        run_instr("cmp_reg", 2'd0, 6'b010101, 4'($urandom), 1'b1, 0, 0);
        run_instr("lsl_reg", 2'd0, 6'b011011, 4'd5, 1'b1, 0, 0);
        run_instr("orr_pc", 2'd0, 6'b111001, 4'd15, 1'b1, 0, 0);
        run_instr("sub_pc_nocond", 2'd0, 6'b000101, 4'd15, 1'b0, 0, 0);
    endtask

    task automatic test_mem();
        run_instr("ldr_stall", 2'd1, 6'b011001, 4'd4, 1'b1, 0, 2);
        run_instr("ldr_pc", 2'd1, 6'b011001, 4'd15, 1'b1, 1, 0);
        run_instr("str_nocond", 2'd1, 6'b011000, 4'd2, 1'b0, 0, 1);
        run_instr("str_stall", 2'd1, 6'b111000, 4'd9, 1'b1, 2, 2);
    endtask

    task automatic test_undef();
        run_instr("undef", 2'd3, 6'($urandom), 4'($urandom), rnd_bit(), 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 40; k++) begin
            run_instr("random", 2'($urandom), 6'($urandom), 4'($urandom),
                      rnd_bit(), $urandom_range(2), $urandom_range(2));
        end
    endtask

    task automatic test_reset_mid_memwr();
        ctl_t got;
        int   dones;
        build(2'd1, 6'b011000, 4'd7, 1'b1, 0, 1);
        play(3, "str_pre_reset", dones);
        bus_if.mem_ready = rdy_q[3];
        #2;
        got = observe();
        checks++;
        if (got !== exp_q[3]) begin
            failures++;
            $display("FAIL memwr_before_reset: got=%h expected=%h", got, exp_q[3]);
        end
        rst_n = 1'b0;
        #1;
        got = observe();
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL memwr_reset_immediate: got=%h expected=0", got);
        end
        bus_if.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        got = observe();
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL memwr_reset_held: got=%h expected=0", got);
        end
        rst_n = 1'b1;
        run_instr("after_reset", 2'd0, 6'b001001, 4'd1, 1'b1, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) alu_tab[i] = 3'b000;
        alu_tab[4'b0010] = 3'b001;
        alu_tab[4'b0000] = 3'b010;
        alu_tab[4'b1100] = 3'b011;
        alu_tab[4'b1010] = 3'b001;
        alu_tab[4'b1000] = 3'b010;
        alu_tab[4'b0101] = 3'b100;

        test_reset();
        test_branch();
        test_dp();
        test_mem();
        test_undef();
        test_back_to_back();
        test_reset_mid_memwr();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
